// File: rtl/evo_i2c_pkg.sv
// Shared definitions for the evo_i2c_target responder: FSM state encoding,
// ACK/NACK bus levels and default configuration values.
package evo_i2c_pkg;

  // Byte-level FSM state, kept as plain constants for legacy tool flows
  typedef logic [2:0] i2c_state_t;

  localparam i2c_state_t ST_IDLE      = 3'd0;
  localparam i2c_state_t ST_ADDR      = 3'd1;
  localparam i2c_state_t ST_ADDR_ACK  = 3'd2;
  localparam i2c_state_t ST_WR_BYTE   = 3'd3;
  localparam i2c_state_t ST_WR_ACK    = 3'd4;
  localparam i2c_state_t ST_RD_BYTE   = 3'd5;
  localparam i2c_state_t ST_RD_ACK    = 3'd6;
  localparam i2c_state_t ST_WAIT_STOP = 3'd7;

  // SDA level during the acknowledge bit
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Default 7-bit target address and glitch-filter depth
  localparam logic [6:0] TGT_ADDR_DEFAULT   = 7'h42;
  localparam int         FILTER_LEN_DEFAULT = 3;

endpackage

// File: rtl/evo_i2c_filter.sv
// Conditions one raw I2C pad line: 2-FF synchronizer, optional glitch
// filter (FILTER_LEN > 0) and rise/fall edge detection. Idle level is high.
module evo_i2c_filter
  import evo_i2c_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic level_s;

  // Synchronizer chain and edge-detect history
  always_comb begin
    sync1_d = line_in;
    sync2_d = sync1_q;
    prev_d  = level_s;
  end

  // Synchronizer and edge-detect flops, reset to the idle-high bus level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  generate
    if (FILTER_LEN > 0) begin : g_filt
      localparam int CW = $clog2(FILTER_LEN) + 1;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          filt_q, filt_d;

      // Accept a new level only after FILTER_LEN consecutive differing samples
      always_comb begin
        cnt_d  = {CW{1'b0}};
        filt_d = filt_q;
        if (sync2_q != filt_q) begin
          if (cnt_q == CW'(FILTER_LEN - 1)) begin
            filt_d = sync2_q;
            cnt_d  = {CW{1'b0}};
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = {CW{1'b0}};
        end
      end

      // Filter state flops
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q  <= {CW{1'b0}};
          filt_q <= 1'b1;
        end else begin
          cnt_q  <= cnt_d;
          filt_q <= filt_d;
        end
      end

      assign level_s = filt_q;
    end else begin : g_bypass
      assign level_s = sync2_q;
    end
  endgenerate

  assign level_o = level_s;
  assign rise_o  = level_s & ~prev_q;
  assign fall_o  = ~level_s & prev_q;

endmodule

// File: rtl/evo_i2c_target.sv
// I2C target bridging SAMD-initiated byte transfers onto an 8-bit register
// bus with an auto-incrementing pointer. Define EVO_I2C_TGT_FILTER_EN to
// enable the SCL/SDA glitch filter (FILTER_LEN samples).
module evo_i2c_target
  import evo_i2c_pkg::*;
#(
  parameter logic [6:0] TGT_ADDR   = TGT_ADDR_DEFAULT,
  parameter int         FILTER_LEN = FILTER_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic       reg_wr_en,
  output logic [7:0] reg_wdata,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

`ifdef EVO_I2C_TGT_FILTER_EN
  localparam int FILT_ON = 1;
`else
  localparam int FILT_ON = 0;
`endif
  localparam int EFF_FILTER_LEN = FILTER_LEN * FILT_ON;

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_s, stop_s;
  logic [7:0] byte_s;

  i2c_state_t state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] ptr_q, ptr_d;
  logic       sda_oe_q, sda_oe_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rd_en_q, rd_en_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic       first_q, first_d;
  logic       cap_q, cap_d;
  logic       inc_q, inc_d;

  evo_i2c_filter #(.FILTER_LEN(EFF_FILTER_LEN)) u_scl (
    .clk     (clk),
    .reset   (reset),
    .line_in (scl_in),
    .level_o (scl_lvl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  evo_i2c_filter #(.FILTER_LEN(EFF_FILTER_LEN)) u_sda (
    .clk     (clk),
    .reset   (reset),
    .line_in (sda_in),
    .level_o (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  // Bus conditions are only legal as SDA edges while SCL is high
  assign start_s = sda_fall & scl_lvl;
  assign stop_s  = sda_rise & scl_lvl;
  assign byte_s  = {shift_q[6:0], sda_lvl};

  // Byte FSM, shifter, pointer and register-bus strobe generation
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    wr_en_d   = 1'b0;
    wdata_d   = wdata_q;
    rd_en_d   = 1'b0;
    busy_d    = busy_q;
    rw_d      = rw_q;
    first_d   = first_q;
    cap_d     = rd_en_q;
    inc_d     = 1'b0;

    // Read data arrives the cycle after the strobe; pointer advances after
    // the capture or one cycle after a write strobe.
    if (cap_q) begin
      shift_d = reg_rdata;
      ptr_d   = ptr_q + 8'd1;
    end else if (inc_q) begin
      ptr_d = ptr_q + 8'd1;
    end else begin
      ptr_d = ptr_q;
    end

    if (start_s) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sda_oe_d = 1'b0;
        end
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (byte_s[7:1] == TGT_ADDR) begin
                state_d = ST_ADDR_ACK;
                rw_d    = byte_s[0];
                first_d = 1'b1;
                busy_d  = 1'b1;
                rd_en_d = byte_s[0];
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end else begin
              state_d = ST_ADDR;
            end
          end else begin
            state_d = ST_ADDR;
          end
        end
        ST_ADDR_ACK: begin
          // First fall drives the ACK, second fall ends the ACK bit
          if (scl_fall) begin
            bit_cnt_d = 3'd0;
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (rw_q) begin
              state_d  = ST_RD_BYTE;
              sda_oe_d = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
            end else begin
              state_d  = ST_WR_BYTE;
              sda_oe_d = 1'b0;
            end
          end else begin
            state_d = ST_ADDR_ACK;
          end
        end
        ST_WR_BYTE: begin
          if (scl_rise) begin
            shift_d   = byte_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = ST_WR_ACK;
              if (first_q) begin
                ptr_d   = byte_s;
                first_d = 1'b0;
              end else begin
                wr_en_d = 1'b1;
                wdata_d = byte_s;
                inc_d   = 1'b1;
              end
            end else begin
              state_d = ST_WR_BYTE;
            end
          end else begin
            state_d = ST_WR_BYTE;
          end
        end
        ST_WR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 3'd0;
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_WR_BYTE;
            end
          end else begin
            state_d = ST_WR_ACK;
          end
        end
        ST_RD_BYTE: begin
          if (scl_rise) begin
            if (bit_cnt_q == 3'd7) begin
              state_d   = ST_RD_ACK;
              bit_cnt_d = 3'd0;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else if (scl_fall) begin
            sda_oe_d = ~shift_q[7];
            shift_d  = {shift_q[6:0], 1'b0};
          end else begin
            state_d = ST_RD_BYTE;
          end
        end
        ST_RD_ACK: begin
          // Release SDA for the initiator's ACK/NACK, then sample it
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            bit_cnt_d = 3'd0;
            if (sda_lvl == I2C_ACK) begin
              state_d = ST_RD_BYTE;
              rd_en_d = 1'b1;
            end else begin
              state_d = ST_WAIT_STOP;
              busy_d  = 1'b0;
            end
          end else begin
            state_d = ST_RD_ACK;
          end
        end
        ST_WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      ptr_q     <= 8'h00;
      sda_oe_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wdata_q   <= 8'h00;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      rw_q      <= 1'b0;
      first_q   <= 1'b0;
      cap_q     <= 1'b0;
      inc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
      wr_en_q   <= wr_en_d;
      wdata_q   <= wdata_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      rw_q      <= rw_d;
      first_q   <= first_d;
      cap_q     <= cap_d;
      inc_q     <= inc_d;
    end
  end

  // SDA is released in the very cycle reset is asserted
  assign sda_oe    = sda_oe_q & ~reset;
  assign reg_addr  = ptr_q;
  assign reg_wr_en = wr_en_q;
  assign reg_wdata = wdata_q;
  assign reg_rd_en = rd_en_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_evo_i2c_target.sv
// Bench for evo_i2c_target: bit-banged I2C initiator, register read
// responder, and a strobe scoreboard checked by an independent monitor.
module tb_evo_i2c_target;
  import evo_i2c_pkg::*;

  typedef struct {
    logic       is_wr;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m;
  logic       sda_m;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic       reg_wr_en;
  logic [7:0] reg_wdata;
  logic       reg_rd_en;
  logic [7:0] reg_rdata;
  logic       busy;

  logic [7:0] mem [256];
  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_fails  = 0;

  // Open-drain SDA: either side can pull low
  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  evo_i2c_target dut (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_m),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wr_en (reg_wr_en),
    .reg_wdata (reg_wdata),
    .reg_rd_en (reg_rd_en),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.is_wr = 1'b1; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_rd(input logic [7:0] a);
    exp_t e;
    e.is_wr = 1'b0; e.addr = a; e.data = 8'h00;
    exp_q.push_back(e);
  endtask

  // One quarter of an SCL period (SCL = clk/40)
  task automatic q();
    repeat (10) @(posedge clk);
  endtask

  task automatic bit_cycle(input logic b, output logic s);
    sda_m = b;
    q();
    scl_m = 1'b1;
    q();
    @(negedge clk);
    s = sda_line;
    q();
    scl_m = 1'b0;
    q();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    q();
    scl_m = 1'b1;
    q();
    sda_m = 1'b0;
    q();
    scl_m = 1'b0;
    q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    q();
    scl_m = 1'b1;
    q();
    sda_m = 1'b1;
    q();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, s);
    chk(name, {31'd0, s}, exp_ack ? {31'd0, I2C_ACK} : {31'd0, I2C_NACK});
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic ack_bit, input string name);
    logic [7:0] got;
    logic       s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      got[i] = s;
    end
    chk(name, {24'd0, got}, {24'd0, exp});
    bit_cycle(ack_bit, s);
  endtask

  // Register-bus read responder: data valid exactly one cycle after reg_rd_en
  initial begin : rd_responder
    logic       pend;
    logic [7:0] pend_addr;
    pend      = 1'b0;
    pend_addr = 8'h00;
    reg_rdata = 8'hEE;
    forever begin
      @(negedge clk);
      if (pend) reg_rdata = mem[pend_addr];
      else      reg_rdata = 8'hEE;
      pend      = reg_rd_en;
      pend_addr = reg_addr;
    end
  end

  // Strobe monitor: every strobe must match the head of the scoreboard
  initial begin : strobe_monitor
    forever begin
      @(negedge clk);
      if (!reset && (reg_wr_en || reg_rd_en)) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++;
          $display("FAIL unexpected_strobe: got wr=%0b rd=%0b addr 0x%0h data 0x%0h, expected no strobe",
                   reg_wr_en, reg_rd_en, reg_addr, reg_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          if (reg_wr_en !== mon_e.is_wr || reg_rd_en !== ~mon_e.is_wr || reg_addr !== mon_e.addr ||
              (mon_e.is_wr && reg_wdata !== mon_e.data)) begin
            n_fails++;
            $display("FAIL strobe: got wr=%0b rd=%0b addr 0x%0h data 0x%0h, expected wr=%0b addr 0x%0h data 0x%0h",
                     reg_wr_en, reg_rd_en, reg_addr, reg_wdata, mon_e.is_wr, mon_e.addr, mon_e.data);
          end
        end
      end
    end
  end

  // Time limit so the bench can never hang
  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'h3C;
    mem[8'h21] = 8'hC3;
    mem[8'h40] = 8'h00;
    reset = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_sda_oe",    {31'd0, sda_oe},    32'd0);
    chk("reset_reg_addr",  {24'd0, reg_addr},  32'h00);
    chk("reset_wr_en",     {31'd0, reg_wr_en}, 32'd0);
    chk("reset_wdata",     {24'd0, reg_wdata}, 32'h00);
    chk("reset_rd_en",     {31'd0, reg_rd_en}, 32'd0);
    chk("reset_busy",      {31'd0, busy},      32'd0);
    reset = 1'b0;
    q();

    // Write two bytes starting at 0x10
    push_wr(8'h10, 8'hA5);
    push_wr(8'h11, 8'h5A);
    i2c_start();
    send_byte(8'h84, 1'b1, "wr_addr_ack");
    chk("wr_busy_high", {31'd0, busy}, 32'd1);
    send_byte(8'h10, 1'b1, "wr_ptr_ack");
    send_byte(8'hA5, 1'b1, "wr_d0_ack");
    send_byte(8'h5A, 1'b1, "wr_d1_ack");
    i2c_stop();
    q();
    chk("wr_busy_low", {31'd0, busy}, 32'd0);
    chk("wr_ptr_after", {24'd0, reg_addr}, 32'h12);

    // Pointer 0x20, repeated START, read two bytes
    push_rd(8'h20);
    push_rd(8'h21);
    i2c_start();
    send_byte(8'h84, 1'b1, "rd_waddr_ack");
    send_byte(8'h20, 1'b1, "rd_ptr_ack");
    i2c_start();
    send_byte(8'h85, 1'b1, "rd_raddr_ack");
    read_byte(8'h3C, I2C_ACK,  "rd_byte0");
    read_byte(8'hC3, I2C_NACK, "rd_byte1");
    chk("rd_nack_busy", {31'd0, busy},   32'd0);
    chk("rd_nack_oe",   {31'd0, sda_oe}, 32'd0);
    chk("rd_ptr_after", {24'd0, reg_addr}, 32'h22);
    i2c_stop();
    q();

    // Address mismatch: no ACK, no strobes
    i2c_start();
    send_byte(8'h90, 1'b0, "mismatch_addr_nack");
    send_byte(8'h00, 1'b0, "mismatch_data_nack");
    chk("mismatch_busy", {31'd0, busy}, 32'd0);
    i2c_stop();
    q();

    // Pointer wrap 0xFF -> 0x00
    push_wr(8'hFF, 8'h11);
    push_wr(8'h00, 8'h22);
    i2c_start();
    send_byte(8'h84, 1'b1, "wrap_addr_ack");
    send_byte(8'hFF, 1'b1, "wrap_ptr_ack");
    send_byte(8'h11, 1'b1, "wrap_d0_ack");
    send_byte(8'h22, 1'b1, "wrap_d1_ack");
    i2c_stop();
    q();
    chk("wrap_ptr_after", {24'd0, reg_addr}, 32'h01);

    // STOP after 4 data bits: partial byte discarded
    i2c_start();
    send_byte(8'h84, 1'b1, "partial_addr_ack");
    send_byte(8'h30, 1'b1, "partial_ptr_ack");
    begin
      logic s;
      bit_cycle(1'b1, s);
      bit_cycle(1'b0, s);
      bit_cycle(1'b1, s);
      bit_cycle(1'b0, s);
    end
    i2c_stop();
    q();
    chk("partial_busy", {31'd0, busy}, 32'd0);
    chk("partial_ptr",  {24'd0, reg_addr}, 32'h30);

    // Reset while a read bit is driven low
    push_rd(8'h40);
    i2c_start();
    send_byte(8'h84, 1'b1, "rst_waddr_ack");
    send_byte(8'h40, 1'b1, "rst_ptr_ack");
    i2c_start();
    send_byte(8'h85, 1'b1, "rst_raddr_ack");
    chk("rst_pre_oe", {31'd0, sda_oe}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_oe_same_cycle", {31'd0, sda_oe}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_ptr",  {24'd0, reg_addr}, 32'h00);
    chk("rst_busy", {31'd0, busy},     32'd0);
    @(negedge clk);
    reset = 1'b0;
    sda_m = 1'b1;
    q();
    scl_m = 1'b1;
    q();

`ifdef EVO_I2C_TGT_FILTER_EN
    // 2-cycle SDA glitch while SCL high must not register as START
    sda_m = 1'b0;
    repeat (2) @(posedge clk);
    sda_m = 1'b1;
    q();
    scl_m = 1'b0;
    q();
    send_byte(8'h84, 1'b0, "filt_glitch_nack");
    i2c_stop();
    q();
    // 4-cycle low is a genuine START
    sda_m = 1'b0;
    repeat (4) @(posedge clk);
    scl_m = 1'b0;
    q();
    send_byte(8'h84, 1'b1, "filt_start_ack");
    i2c_stop();
    q();
`endif

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
